// File: rtl/udm_bus_arb.sv
// Two-master arbiter for the UDM req/ack bus, with read-response routing by issuing master.
// Define UDM_ARB_M0_PRIO_EN for fixed master-0 priority; the default build is round-robin.
module udm_bus_arb #(
  parameter int RD_DEPTH = 4,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_bi,
  input  logic [DW/8-1:0] m0_be_bi,
  input  logic [DW-1:0]   m0_wdata_bi,
  output logic            m0_ack_o,
  output logic            m0_resp_o,
  output logic [DW-1:0]   m0_rdata_bo,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_bi,
  input  logic [DW/8-1:0] m1_be_bi,
  input  logic [DW-1:0]   m1_wdata_bi,
  output logic            m1_ack_o,
  output logic            m1_resp_o,
  output logic [DW-1:0]   m1_rdata_bo,
  output logic            s_req_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_bo,
  output logic [DW/8-1:0] s_be_bo,
  output logic [DW-1:0]   s_wdata_bo,
  input  logic            s_ack_i,
  input  logic            s_resp_i,
  input  logic [DW-1:0]   s_rdata_bi,
  output logic            err_o
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [RD_DEPTH-1:0] ids_q, ids_d;
  logic                m0_resp_q, m0_resp_d, m1_resp_q, m1_resp_d;
  logic [DW-1:0]       m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                err_q, err_d;

  logic rd_full, m0_elig, m1_elig, gnt_vld, gnt_id, accept, push, pop, head;

  // Eligibility uses the registered count, so a same-cycle pop never unblocks a read.
  assign rd_full = (cnt_q == CW'(RD_DEPTH));
  assign m0_elig = m0_req_i && (m0_we_i || !rd_full);
  assign m1_elig = m1_req_i && (m1_we_i || !rd_full);
  assign gnt_vld = (m0_elig || m1_elig) && arst_n_i;

`ifdef UDM_ARB_M0_PRIO_EN
  assign gnt_id = !m0_elig;
`else
  logic rr_ptr_q, rr_ptr_d;

  assign gnt_id = (m0_elig && m1_elig) ? rr_ptr_q : !m0_elig;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = !gnt_id;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) rr_ptr_q <= 1'b0;
    else           rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    if (gnt_vld) begin
      s_req_o    = 1'b1;
      s_we_o     = gnt_id ? m1_we_i     : m0_we_i;
      s_addr_bo  = gnt_id ? m1_addr_bi  : m0_addr_bi;
      s_be_bo    = gnt_id ? m1_be_bi    : m0_be_bi;
      s_wdata_bo = gnt_id ? m1_wdata_bi : m0_wdata_bi;
    end
  end

  assign accept   = gnt_vld && s_ack_i;
  assign m0_ack_o = accept && !gnt_id;
  assign m1_ack_o = accept && gnt_id;

  assign push = accept && !s_we_o;
  assign pop  = s_resp_i && (cnt_q != '0);
  assign head = ids_q[rd_ptr_q];

  always_comb begin
    ids_d    = ids_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      ids_d[wr_ptr_q] = gnt_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // Responses are single-cycle pulses; the idle master always sees zero data.
  always_comb begin
    m0_resp_d  = pop && !head;
    m1_resp_d  = pop && head;
    m0_rdata_d = m0_resp_d ? s_rdata_bi : '0;
    m1_rdata_d = m1_resp_d ? s_rdata_bi : '0;
    err_d      = err_q || (s_resp_i && (cnt_q == '0));
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ids_q      <= '0;
      m0_resp_q  <= 1'b0;
      m1_resp_q  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ids_q      <= ids_d;
      m0_resp_q  <= m0_resp_d;
      m1_resp_q  <= m1_resp_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      err_q      <= err_d;
    end
  end

  assign m0_resp_o   = m0_resp_q;
  assign m1_resp_o   = m1_resp_q;
  assign m0_rdata_bo = m0_rdata_q;
  assign m1_rdata_bo = m1_rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_udm_bus_arb.sv
// Bench for udm_bus_arb: directed scenarios then randomized traffic against a queue-based model.
module tb_udm_bus_arb;
  localparam int RD_DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic arst_n_i;
  logic m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [AW-1:0] m0_addr_bi, m1_addr_bi, s_addr_bo;
  logic [DW/8-1:0] m0_be_bi, m1_be_bi, s_be_bo;
  logic [DW-1:0] m0_wdata_bi, m1_wdata_bi, s_wdata_bo, s_rdata_bi;
  logic [DW-1:0] m0_rdata_bo, m1_rdata_bo;
  logic m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic s_req_o, s_we_o, s_ack_i, s_resp_i, err_o;

  udm_bus_arb #(.RD_DEPTH(RD_DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi),
    .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi),
    .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
    .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
    .err_o(err_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of issuing-master ids, preferred master, sticky error, expected pulses.
  int q[$];
  bit pref, err_m, er0, er1;
  logic [DW-1:0] ed0, ed1;
  bit last_ack0, last_ack1;
  bit nx_er0, nx_er1, nx_err, nx_pref, nx_push, nx_pop, nx_g;
  logic [DW-1:0] nx_ed0, nx_ed1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pref = 0; err_m = 0; er0 = 0; er1 = 0; ed0 = '0; ed1 = '0;
  endtask

  task automatic idle();
    m0_req_i = 0; m0_we_i = 0; m0_addr_bi = '0; m0_be_bi = '0; m0_wdata_bi = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_bi = '0; m1_be_bi = '0; m1_wdata_bi = '0;
    s_ack_i = 0; s_resp_i = 0; s_rdata_bi = '0;
  endtask

  // Called at posedge+1 with inputs set; checks at posedge+5 and computes the model's next state.
  task automatic settle_check();
    bit full, e0, e1, g, gv, acc, we_g;
    #4;
    full = (q.size() >= RD_DEPTH);
    e0 = m0_req_i && (m0_we_i || !full);
    e1 = m1_req_i && (m1_we_i || !full);
`ifdef UDM_ARB_M0_PRIO_EN
    g = !e0;
`else
    g = (e0 && e1) ? pref : !e0;
`endif
    gv = (e0 || e1) && arst_n_i;
    we_g = g ? m1_we_i : m0_we_i;
    chk("s_req", s_req_o, gv);
    chk("s_we", s_we_o, gv ? we_g : 1'b0);
    chk("s_addr", s_addr_bo, gv ? (g ? m1_addr_bi : m0_addr_bi) : '0);
    chk("s_be", s_be_bo, gv ? (g ? m1_be_bi : m0_be_bi) : '0);
    chk("s_wdata", s_wdata_bo, gv ? (g ? m1_wdata_bi : m0_wdata_bi) : '0);
    acc = gv && s_ack_i;
    chk("m0_ack", m0_ack_o, acc && !g);
    chk("m1_ack", m1_ack_o, acc && g);
    chk("m0_resp", m0_resp_o, er0);
    chk("m1_resp", m1_resp_o, er1);
    chk("m0_rdata", m0_rdata_bo, ed0);
    chk("m1_rdata", m1_rdata_bo, ed1);
    chk("err", err_o, err_m);
    last_ack0 = acc && !g;
    last_ack1 = acc && g;
    nx_pop = s_resp_i && (q.size() > 0);
    nx_er0 = 0; nx_er1 = 0; nx_ed0 = '0; nx_ed1 = '0;
    if (nx_pop) begin
      if (q[0] == 0) begin nx_er0 = 1; nx_ed0 = s_rdata_bi; end
      else begin nx_er1 = 1; nx_ed1 = s_rdata_bi; end
    end
    nx_err = err_m || (s_resp_i && q.size() == 0);
    nx_push = acc && !we_g;
    nx_g = g;
    nx_pref = acc ? !g : pref;
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (nx_pop) void'(q.pop_front());
    if (nx_push) q.push_back(int'(nx_g));
    er0 = nx_er0; er1 = nx_er1; ed0 = nx_ed0; ed1 = nx_ed1;
    err_m = nx_err; pref = nx_pref;
    #1;
  endtask

  task automatic cycle();
    settle_check();
    tick();
  endtask

  task automatic do_reset();
    idle();
    arst_n_i = 0;
    model_reset();
    @(posedge clk_i);
    #1;
    arst_n_i = 1;
  endtask

  initial begin
    bit exp0;
    idle();
    arst_n_i = 0;
    model_reset();
    #12;
    chk("rst_s_req", s_req_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_m0_resp", m0_resp_o, 1'b0);
    chk("rst_m1_rdata", m1_rdata_bo, '0);
    arst_n_i = 1;
    @(posedge clk_i);
    #1;

    // Single write from master 0.
    m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h0; m0_be_bi = 4'hF; m0_wdata_bi = 32'h1234;
    s_ack_i = 1;
    settle_check();
    chk("t2_s_we", s_we_o, 1'b1);
    chk("t2_s_wdata", s_wdata_bo, 32'h1234);
    chk("t2_m0_ack", m0_ack_o, 1'b1);
    chk("t2_m1_ack", m1_ack_o, 1'b0);
    tick();
    idle();

    // Async reset in the middle of a read; count must be zero afterwards.
    m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h8; m0_be_bi = 4'hF; s_ack_i = 1;
    cycle();
    s_ack_i = 0;
    #2;
    arst_n_i = 0;
    model_reset();
    #2;
    chk("t1_s_req_low", s_req_o, 1'b0);
    chk("t1_m0_ack_low", m0_ack_o, 1'b0);
    chk("t1_m0_resp_low", m0_resp_o, 1'b0);
    chk("t1_err_low", err_o, 1'b0);
    @(posedge clk_i);
    #1;
    idle();
    arst_n_i = 1;
    s_resp_i = 1; s_rdata_bi = 32'hDEAD;
    cycle();
    s_resp_i = 0;
    settle_check();
    chk("t1_stale_err", err_o, 1'b1);
    chk("t1_stale_resp", m0_resp_o, 1'b0);
    tick();

    // Both masters reading back-to-back.
    do_reset();
    m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h10; m0_be_bi = 4'hF;
    m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h20; m1_be_bi = 4'h3;
    s_ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      settle_check();
`ifdef UDM_ARB_M0_PRIO_EN
      exp0 = 1;
`else
      exp0 = (i % 2 == 0);
`endif
      chk("t3_m0_ack", m0_ack_o, exp0);
      chk("t3_m1_ack", m1_ack_o, !exp0);
      tick();
    end

    // In-order responses routed to their issuing masters.
    do_reset();
    m0_req_i = 1; m0_we_i = 0; m0_addr_bi = 32'h4; m0_be_bi = 4'hF; s_ack_i = 1;
    cycle();
    m0_req_i = 0;
    m1_req_i = 1; m1_we_i = 0; m1_addr_bi = 32'h0; m1_be_bi = 4'hF;
    cycle();
    idle();
    s_resp_i = 1; s_rdata_bi = 32'hAAAA;
    cycle();
    s_rdata_bi = 32'h5555;
    settle_check();
    chk("t4_m0_resp", m0_resp_o, 1'b1);
    chk("t4_m0_rdata", m0_rdata_bo, 32'hAAAA);
    chk("t4_m1_resp0", m1_resp_o, 1'b0);
    tick();
    s_resp_i = 0;
    settle_check();
    chk("t4_m1_resp", m1_resp_o, 1'b1);
    chk("t4_m1_rdata", m1_rdata_bo, 32'h5555);
    chk("t4_m0_pulse", m0_resp_o, 1'b0);
    chk("t4_m0_rdata0", m0_rdata_bo, '0);
    tick();
    settle_check();
    chk("t4_m1_pulse", m1_resp_o, 1'b0);
    tick();

    // Read FIFO full: reads stall, writes proceed, a pop unblocks on the following cycle.
    do_reset();
    m0_req_i = 1; m0_we_i = 0; m0_be_bi = 4'hF; s_ack_i = 1;
    for (int i = 0; i < RD_DEPTH; i++) begin
      m0_addr_bi = 32'(i * 4);
      cycle();
    end
    m0_addr_bi = 32'h100;
    m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h40; m1_be_bi = 4'hF; m1_wdata_bi = 32'hCAFE;
    settle_check();
    chk("t5_full_m0_ack", m0_ack_o, 1'b0);
    chk("t5_full_m1_wr_ack", m1_ack_o, 1'b1);
    tick();
    m1_req_i = 0;
    s_resp_i = 1; s_rdata_bi = 32'h77;
    settle_check();
    chk("t5_pop_cycle_ack", m0_ack_o, 1'b0);
    tick();
    s_resp_i = 0;
    settle_check();
    chk("t5_after_pop_ack", m0_ack_o, 1'b1);
    tick();

    // Response with nothing outstanding.
    do_reset();
    s_resp_i = 1; s_rdata_bi = 32'h9;
    cycle();
    s_resp_i = 0;
    settle_check();
    chk("t6_err", err_o, 1'b1);
    chk("t6_m0_resp", m0_resp_o, 1'b0);
    chk("t6_m1_resp", m1_resp_o, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) cycle();
    settle_check();
    chk("t6_err_held", err_o, 1'b1);
    tick();
    do_reset();
    settle_check();
    chk("t6_err_cleared", err_o, 1'b0);
    tick();

    // Randomized traffic; masters hold their fields until acked.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      s_ack_i = ($urandom_range(0, 3) != 0);
      s_resp_i = ($urandom_range(0, 2) == 0) && (q.size() > 0 || $urandom_range(0, 199) == 0);
      s_rdata_bi = $urandom;
      if (!m0_req_i && $urandom_range(0, 2) != 0) begin
        m0_req_i = 1; m0_we_i = $urandom_range(0, 1) == 1;
        m0_addr_bi = $urandom; m0_be_bi = 4'($urandom); m0_wdata_bi = $urandom;
      end
      if (!m1_req_i && $urandom_range(0, 2) != 0) begin
        m1_req_i = 1; m1_we_i = $urandom_range(0, 1) == 1;
        m1_addr_bi = $urandom; m1_be_bi = 4'($urandom); m1_wdata_bi = $urandom;
      end
      cycle();
      if (last_ack0) m0_req_i = 0;
      if (last_ack1) m1_req_i = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
